pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch program counter and sequences the PC incrementer (Out = In + 4) against branch, jump, exception and exception-return redirects.
- Implements one-instruction branch delay-slot semantics.
- Handshakes fetch addresses with the instruction memory interface.
- Sits between the decode/execute control logic and the IF stage.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- EXC_VECTOR, 32'hBFC0_0380, PC value loaded on exception or address error.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- nReset  input  1  asynchronous active-low reset.
- Stall  input  1  pipeline stall; blocks PC advance.
- FetchReady  input  1  imem accepts the address on PC this cycle.
- BranchTaken  input  1  taken branch resolved this cycle.
- BranchTarget  input  32  branch destination.
- Jump  input  1  jump resolved this cycle.
- JumpTarget  input  32  jump destination.
- Exception  input  1  exception request.
- ExcReturn  input  1  return from exception.
- EPC  input  32  exception return address.
- PC  output  32  current fetch address.
- PCPlus4  output  32  incrementer result (PC + 4, modulo 2^32), combinational.
- FetchValid  output  1  PC is a valid fetch request.
- DelaySlot  output  1  current PC is a branch/jump delay slot.
- AddrError  output  1  one-cycle pulse: misaligned redirect target.
- Overflow  output  1  one-cycle pulse: PC wrapped from 32'hFFFF_FFFC to 0.

Behaviour:
- Reset values (asynchronous, while nReset=0):
  - PC=RESET_VECTOR; state=BOOT; FetchValid=0; DelaySlot=0; AddrError=0; Overflow=0; target register=0.
- Advance condition: adv = FetchValid & FetchReady & ~Stall.
- States: BOOT, RUN, DELAY.
  - BOOT: FetchValid=0 for exactly one cycle after reset release, then RUN. PC is unchanged.
  - RUN, adv, BranchTaken or Jump asserted:
    - Capture the target into the target register (branch has priority over jump).
    - PC <= PCPlus4; state <= DELAY; DelaySlot=1 in the next cycle.
  - RUN, adv, no redirect: PC <= PCPlus4.
  - DELAY, adv: PC <= target register; state <= RUN; DelaySlot=0.
  - DELAY: BranchTaken and Jump are ignored (no nested delay slots).
  - No adv: PC, state and target register hold.
- FetchValid=1 in RUN and DELAY.
- Exception and ExcReturn act regardless of Stall, FetchReady and state (including BOOT).
  - Exception: PC <= EXC_VECTOR; state <= RUN; pending target discarded; DelaySlot <= 0.
  - ExcReturn: PC <= EPC; state <= RUN; pending target discarded; DelaySlot <= 0.
- Priority: Exception > ExcReturn > BranchTaken > Jump > increment.
- Alignment: a redirect whose bits [1:0] != 0 (BranchTarget/JumpTarget when captured, EPC on ExcReturn):
  - The redirect is dropped; PC <= EXC_VECTOR; state <= RUN.
  - AddrError pulses high for one cycle.
- Wrap-around: PCPlus4 = PC + 4 truncated to 32 bits. When an increment is taken with PC=32'hFFFF_FFFC:
  - PC becomes 0.
  - Overflow pulses for one cycle, registered alongside the PC update.
  - No other effect.
- Latency: every redirect reaches PC one clock after the qualifying edge; no combinational path from inputs to PC.
- Reset mid-operation: nReset low forces reset values immediately; the pending delay-slot target is lost.

Test Plan:
- Reset, then release with FetchReady=1 → PC=32'hBFC0_0000, FetchValid=0 for one cycle, then PC=BFC0_0004, BFC0_0008 on successive cycles.
- BranchTaken=1, BranchTarget=32'h0000_1000 at PC=32'h100 → PC=32'h104 with DelaySlot=1, then PC=32'h1000 with DelaySlot=0.
- Stall=1 for 3 cycles during DELAY at PC=32'h104 → PC holds 32'h104 with DelaySlot=1, then PC=32'h1000 one cycle after Stall drops.
- Exception=1 together with BranchTaken=1 and Stall=1 → PC=32'hBFC0_0380 next cycle, DelaySlot=0, branch discarded.
- Jump with JumpTarget=32'h0000_2002 → AddrError pulses one cycle, PC=32'hBFC0_0380; ExcReturn with EPC=32'h2000 → PC=32'h2000 next cycle.
- Force PC=32'hFFFF_FFFC via ExcReturn/EPC, then FetchReady=1 → PC=0, Overflow pulses exactly one cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with incrementer, redirects and one-instruction delay slot
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        Stall,
   input  logic        FetchReady,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        Exception,
   input  logic        ExcReturn,
   input  logic [31:0] EPC,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        FetchValid,
   output logic        DelaySlot,
   output logic        AddrError,
   output logic        Overflow
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DELAY = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        delay_slot_q, delay_slot_d;
   logic        addr_error_q, addr_error_d;
   logic        overflow_q, overflow_d;

   logic [31:0] pc_plus4;
   logic        pc_wraps;
   logic        adv;
   logic        redirect_req;
   logic [31:0] redirect_tgt;

   // Incrementer wraps naturally at 32 bits; the wrap case is flagged separately.
   assign pc_plus4     = pc_q + 32'd4;
   assign pc_wraps     = (pc_q == 32'hFFFF_FFFC);
   assign adv          = fetch_valid_q & FetchReady & ~Stall;
   assign redirect_req = BranchTaken | Jump;
   // Branch wins over jump when both resolve in the same cycle.
   assign redirect_tgt = BranchTaken ? BranchTarget : JumpTarget;

   assign PC         = pc_q;
   assign PCPlus4    = pc_plus4;
   assign FetchValid = fetch_valid_q;
   assign DelaySlot  = delay_slot_q;
   assign AddrError  = addr_error_q;
   assign Overflow   = overflow_q;

   // Next-state and next-PC selection: exception, exception return, then delay-slot sequencing.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      addr_error_d = 1'b0;
      overflow_d   = 1'b0;

      if (Exception) begin
         pc_d     = EXC_VECTOR;
         state_d  = ST_RUN;
         target_d = 32'd0;
      end else if (ExcReturn) begin
         // A misaligned return address is turned into an address-error trap.
         if (EPC[1:0] != 2'b00) begin
            pc_d         = EXC_VECTOR;
            addr_error_d = 1'b1;
         end else begin
            pc_d = EPC;
         end
         state_d  = ST_RUN;
         target_d = 32'd0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               // One idle cycle after reset before the first fetch is offered.
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (adv) begin
                  if (redirect_req) begin
                     if (redirect_tgt[1:0] != 2'b00) begin
                        // Misaligned target: drop the redirect and trap instead of entering the slot.
                        pc_d         = EXC_VECTOR;
                        addr_error_d = 1'b1;
                        state_d      = ST_RUN;
                     end else begin
                        // Fetch the delay slot next, remember where to go after it.
                        target_d   = redirect_tgt;
                        pc_d       = pc_plus4;
                        overflow_d = pc_wraps;
                        state_d    = ST_DELAY;
                     end
                  end else begin
                     pc_d       = pc_plus4;
                     overflow_d = pc_wraps;
                  end
               end
            end
            ST_DELAY: begin
               // Redirects arriving while in the slot are ignored; no nested slots.
               if (adv) begin
                  pc_d    = target_q;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end

      fetch_valid_d = (state_d != ST_BOOT);
      delay_slot_d  = (state_d == ST_DELAY);
   end

   // Sequencer state and registered outputs; async reset restores the boot vector.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_VECTOR;
         target_q      <= 32'd0;
         fetch_valid_q <= 1'b0;
         delay_slot_q  <= 1'b0;
         addr_error_q  <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         target_q      <= target_d;
         fetch_valid_q <= fetch_valid_d;
         delay_slot_q  <= delay_slot_d;
         addr_error_q  <= addr_error_d;
         overflow_q    <= overflow_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table and scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'hBFC0_0000;
   localparam logic [31:0] EV = 32'hBFC0_0380;

   logic        Clock = 1'b0;
   logic        nReset = 1'b1;
   logic        Stall = 1'b0;
   logic        FetchReady = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'd0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = 32'd0;
   logic        Exception = 1'b0;
   logic        ExcReturn = 1'b0;
   logic [31:0] EPC = 32'd0;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        FetchValid;
   logic        DelaySlot;
   logic        AddrError;
   logic        Overflow;

   // flags = {FetchValid, DelaySlot, AddrError, Overflow}
   typedef struct packed {
      logic        stall;
      logic        ready;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] pc;
      logic [3:0]  flags;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 Clock = ~Clock;

   pc_sequencer dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .Stall        (Stall),
      .FetchReady   (FetchReady),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .Exception    (Exception),
      .ExcReturn    (ExcReturn),
      .EPC          (EPC),
      .PC           (PC),
      .PCPlus4      (PCPlus4),
      .FetchValid   (FetchValid),
      .DelaySlot    (DelaySlot),
      .AddrError    (AddrError),
      .Overflow     (Overflow)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic stall, input logic ready, input logic br, input logic [31:0] bt,
                               input logic jmp, input logic [31:0] jt, input logic exc, input logic eret,
                               input logic [31:0] epc, input logic [31:0] pc, input logic [3:0] flags);
      vec_t v;
      v.stall = stall; v.ready = ready; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
      v.exc = exc; v.eret = eret; v.epc = epc; v.pc = pc; v.flags = flags;
      return v;
   endfunction

   task automatic check_outputs(input int idx, input logic [31:0] pc, input logic [3:0] flags);
      check("pc", idx, PC, pc);
      check("pcplus4", idx, PCPlus4, pc + 32'd4);
      check("flags", idx, {28'd0, FetchValid, DelaySlot, AddrError, Overflow}, {28'd0, flags});
   endtask

   task automatic step(input vec_t v, input int idx);
      vec_t e;
      @(negedge Clock);
      Stall = v.stall; FetchReady = v.ready;
      BranchTaken = v.br; BranchTarget = v.bt;
      Jump = v.jmp; JumpTarget = v.jt;
      Exception = v.exc; ExcReturn = v.eret; EPC = v.epc;
      exp_q.push_back(v);
      @(posedge Clock);
      #1;
      e = exp_q.pop_front();
      check_outputs(idx, e.pc, e.flags);
   endtask

   initial begin
      //               st rd br bt            j  jt            ex er epc           pc             flags
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        RV,            4'b1000)); // 0 boot
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        RV + 32'd4,    4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        RV + 32'd8,    4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h100,      32'h100,       4'b1000));
      tbl.push_back(mk(0, 1, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        32'h104,       4'b1100)); // 4 branch
      tbl.push_back(mk(1, 1, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        32'h104,       4'b1100));
      tbl.push_back(mk(1, 1, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        32'h104,       4'b1100));
      tbl.push_back(mk(1, 1, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        32'h104,       4'b1100));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h3000,     0, 0, 32'h0,        32'h1000,      4'b1000)); // 8 slot exit
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h1000,      4'b1000));
      tbl.push_back(mk(0, 0, 1, 32'h7000,     0, 32'h0,        0, 0, 32'h0,        32'h1000,      4'b1000));
      tbl.push_back(mk(0, 1, 1, 32'h4000,     1, 32'h2000,     0, 0, 32'h0,        32'h1004,      4'b1100)); // 11 br > jmp
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h4000,      4'b1000));
      tbl.push_back(mk(0, 1, 1, 32'h5000,     0, 32'h0,        0, 0, 32'h0,        32'h4004,      4'b1100));
      tbl.push_back(mk(1, 1, 1, 32'h6000,     0, 32'h0,        1, 0, 32'h0,        EV,            4'b1000)); // 14 exc in slot
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        EV + 32'd4,    4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h100,      EV,            4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2002,     0, 0, 32'h0,        EV,            4'b1010)); // 17 bad jump
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        EV + 32'd4,    4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2000,     32'h2000,      4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2001,     EV,            4'b1010)); // 20 bad epc
      tbl.push_back(mk(0, 1, 1, 32'h3,        0, 32'h0,        0, 0, 32'h0,        EV,            4'b1010));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000));
      tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC, 4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,         4'b1001)); // 24 wrap
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h4,         4'b1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000));
      tbl.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,        0, 0, 32'h0,        32'h0,         4'b1101)); // 27 wrap into slot
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h80,        4'b1000));
      tbl.push_back(mk(0, 1, 1, 32'h9000,     0, 32'h0,        0, 0, 32'h0,        32'h84,        4'b1100));
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h200,      32'h200,       4'b1000)); // 30 eret in slot
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h204,       4'b1000));
      tbl.push_back(mk(0, 0, 1, 32'h2,        0, 32'h0,        0, 0, 32'h0,        32'h204,       4'b1000));

      FetchReady = 1'b1;
      #1 nReset = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check_outputs(100, RV, 4'b0000);
      nReset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], i);
      end

      // Reset asserted while a delay-slot target is pending: target must be lost.
      step(mk(0, 1, 1, 32'hA000, 0, 32'h0, 0, 0, 32'h0, 32'h208, 4'b1100), 200);
      BranchTaken = 1'b0;
      #2 nReset = 1'b0;
      #1;
      check_outputs(201, RV, 4'b0000);
      nReset = 1'b1;
      step(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, RV, 4'b1000), 202);
      step(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, RV + 32'd4, 4'b1000), 203);

      // Exception taken during the boot cycle.
      #2 nReset = 1'b0;
      #1;
      check_outputs(300, RV, 4'b0000);
      nReset = 1'b1;
      step(mk(0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, EV, 4'b1000), 301);
      step(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, EV + 32'd4, 4'b1000), 302);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
